cds_sample_subtractor: RTL and testbench

- Consumer end of the CDS clock interface: watches cds_clk1 (reset-level window), cds_clk2 (signal-level window) and cds_done from the CDS clock generator.
- Accumulates ADC samples during each window and computes the correlated-double-sample difference.
- Presents one result per frame to downstream readout logic; sits between the ADC capture register and the readout FIFO/serializer.

---
 rtl/cds_sample_subtractor.sv | 188 ++++++++++++++++++
 tb/tb_cds_sample_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cds_sample_subtractor.sv
// CDS sample subtractor: sums ADC samples over the reset (cds_clk1) and signal (cds_clk2)
// windows of each frame and presents sum1 - sum2 with frame error flags once per frame.
module cds_sample_subtractor #(
  parameter int unsigned ADC_W = 12,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ACC_W = ADC_W + CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cds_clk1,
  input  logic                    cds_clk2,
  input  logic                    cds_done,
  input  logic [ADC_W-1:0]        adc_data,
  output logic signed [ACC_W:0]   cds_diff,
  output logic [ACC_W-1:0]        sum1,
  output logic [ACC_W-1:0]        sum2,
  output logic [CNT_W-1:0]        cnt1,
  output logic [CNT_W-1:0]        cnt2,
  output logic                    result_valid,
  output logic                    seq_err,
  output logic                    sat_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIN1,
    S_GAP,
    S_WIN2,
    S_WAIT_DONE,
    S_OUT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc1, r_acc2, w_acc1_nxt, w_acc2_nxt;
  logic [CNT_W-1:0] r_cnt1, r_cnt2, w_cnt1_nxt, w_cnt2_nxt;
  logic             r_seq_err, r_sat_err, w_seq_nxt, w_sat_nxt;

  logic [ACC_W-1:0] w_acc1_inc, w_acc2_inc;
  logic [CNT_W-1:0] w_cnt1_inc, w_cnt2_inc;
  logic             w_full1, w_full2;

  assign w_acc1_inc = r_acc1 + ACC_W'(adc_data);
  assign w_acc2_inc = r_acc2 + ACC_W'(adc_data);
  assign w_cnt1_inc = r_cnt1 + CNT_W'(1);
  assign w_cnt2_inc = r_cnt2 + CNT_W'(1);
  assign w_full1    = (r_cnt1 == CNT_MAX);
  assign w_full2    = (r_cnt2 == CNT_MAX);

  // Frame sequencing and accumulation; a full window drops samples and flags saturation
  always_comb begin
    w_state_nxt = r_state;
    w_acc1_nxt  = r_acc1;
    w_acc2_nxt  = r_acc2;
    w_cnt1_nxt  = r_cnt1;
    w_cnt2_nxt  = r_cnt2;
    w_seq_nxt   = r_seq_err;
    w_sat_nxt   = r_sat_err;

    if (cds_clk1 && cds_clk2 && (r_state != S_OUT)) w_seq_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_acc1_nxt = '0;
        w_acc2_nxt = '0;
        w_cnt1_nxt = '0;
        w_cnt2_nxt = '0;
        if (cds_clk1) begin
          w_acc1_nxt  = ACC_W'(adc_data);
          w_cnt1_nxt  = CNT_W'(1);
          w_state_nxt = S_WIN1;
        end else if (cds_clk2) begin
          w_seq_nxt = 1'b1;
        end
      end
      S_WIN1: begin
        if (cds_done) begin
          w_seq_nxt   = 1'b1;
          w_state_nxt = S_OUT;
        end else if (cds_clk1) begin
          if (w_full1) begin
            w_sat_nxt = 1'b1;
          end else begin
            w_acc1_nxt = w_acc1_inc;
            w_cnt1_nxt = w_cnt1_inc;
          end
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cds_done) begin
          w_seq_nxt   = 1'b1;
          w_state_nxt = S_OUT;
        end else if (cds_clk1) begin
          w_seq_nxt   = 1'b1;
          w_state_nxt = S_WIN1;
          if (w_full1) begin
            w_sat_nxt = 1'b1;
          end else begin
            w_acc1_nxt = w_acc1_inc;
            w_cnt1_nxt = w_cnt1_inc;
          end
        end else if (cds_clk2) begin
          w_acc2_nxt  = ACC_W'(adc_data);
          w_cnt2_nxt  = CNT_W'(1);
          w_state_nxt = S_WIN2;
        end
      end
      S_WIN2: begin
        if (cds_clk2) begin
          if (w_full2) begin
            w_sat_nxt = 1'b1;
          end else begin
            w_acc2_nxt = w_acc2_inc;
            w_cnt2_nxt = w_cnt2_inc;
          end
          if (cds_done) w_state_nxt = S_OUT;
        end else if (cds_done) begin
          w_state_nxt = S_OUT;
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (cds_clk1 || cds_clk2) w_seq_nxt = 1'b1;
        if (cds_done) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_acc1_nxt  = '0;
        w_acc2_nxt  = '0;
        w_cnt1_nxt  = '0;
        w_cnt2_nxt  = '0;
        w_seq_nxt   = 1'b0;
        w_sat_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_acc1    <= '0;
      r_acc2    <= '0;
      r_cnt1    <= '0;
      r_cnt2    <= '0;
      r_seq_err <= 1'b0;
      r_sat_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc1    <= w_acc1_nxt;
      r_acc2    <= w_acc2_nxt;
      r_cnt1    <= w_cnt1_nxt;
      r_cnt2    <= w_cnt2_nxt;
      r_seq_err <= w_seq_nxt;
      r_sat_err <= w_sat_nxt;
    end
  end

  // Results load on the edge that enters OUT so result_valid follows the done edge directly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cds_diff     <= '0;
      sum1         <= '0;
      sum2         <= '0;
      cnt1         <= '0;
      cnt2         <= '0;
      result_valid <= 1'b0;
      seq_err      <= 1'b0;
      sat_err      <= 1'b0;
    end else begin
      result_valid <= (w_state_nxt == S_OUT);
      if (w_state_nxt == S_OUT) begin
        cds_diff <= $signed({1'b0, w_acc1_nxt}) - $signed({1'b0, w_acc2_nxt});
        sum1     <= w_acc1_nxt;
        sum2     <= w_acc2_nxt;
        cnt1     <= w_cnt1_nxt;
        cnt2     <= w_cnt2_nxt;
        seq_err  <= w_seq_nxt;
        sat_err  <= w_sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cds_sample_subtractor.sv
// Scoreboard bench for cds_sample_subtractor: directed frames push expected results,
// an independent monitor pops and compares on every result_valid pulse.
module tb_cds_sample_subtractor;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ACC_W = ADC_W + CNT_W;

  logic                  clk;
  logic                  reset;
  logic                  cds_clk1, cds_clk2, cds_done;
  logic [ADC_W-1:0]      adc_data;
  logic signed [ACC_W:0] cds_diff;
  logic [ACC_W-1:0]      sum1, sum2;
  logic [CNT_W-1:0]      cnt1, cnt2;
  logic                  result_valid, seq_err, sat_err;

  cds_sample_subtractor #(.ADC_W(ADC_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cds_clk1     (cds_clk1),
    .cds_clk2     (cds_clk2),
    .cds_done     (cds_done),
    .adc_data     (adc_data),
    .cds_diff     (cds_diff),
    .sum1         (sum1),
    .sum2         (sum2),
    .cnt1         (cnt1),
    .cnt2         (cnt2),
    .result_valid (result_valid),
    .seq_err      (seq_err),
    .sat_err      (sat_err)
  );

  typedef struct {
    int     id;
    int     cyc;
    longint diff;
    longint s1;
    longint s2;
    int     c1;
    int     c2;
    int     seq;
    int     sat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic c1, input logic c2, input logic d, input logic [ADC_W-1:0] data);
    @(negedge clk);
    cds_clk1 = c1;
    cds_clk2 = c2;
    cds_done = d;
    adc_data = data;
  endtask

  task automatic win(input logic c1, input logic c2, input logic [ADC_W-1:0] data, input int n);
    repeat (n) step(c1, c2, 1'b0, data);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Called right after the cycle that presents cds_done is driven
  task automatic push_exp(input int id, input longint diff, input longint s1, input longint s2,
                          input int c1, input int c2, input int seq, input int sat);
    exp_t e;
    e.id = id; e.cyc = cyc + 1; e.diff = diff; e.s1 = s1; e.s2 = s2;
    e.c1 = c1; e.c2 = c2; e.seq = seq; e.sat = sat;
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, longint'(result_valid), 0);
    chk({tag, "_diff"},  longint'(cds_diff), 0);
    chk({tag, "_sum1"},  longint'(sum1), 0);
    chk({tag, "_sum2"},  longint'(sum2), 0);
    chk({tag, "_cnt1"},  longint'(cnt1), 0);
    chk({tag, "_cnt2"},  longint'(cnt2), 0);
    chk({tag, "_seq"},   longint'(seq_err), 0);
    chk({tag, "_sat"},   longint'(sat_err), 0);
  endtask

  // Monitor: every result pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: result_valid=1 at cycle %0d, expected no pending frame", cyc);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("f%0d_latency", e.id), longint'(cyc), longint'(e.cyc));
          chk($sformatf("f%0d_diff", e.id), longint'($signed(cds_diff)), e.diff);
          chk($sformatf("f%0d_sum1", e.id), longint'(sum1), e.s1);
          chk($sformatf("f%0d_sum2", e.id), longint'(sum2), e.s2);
          chk($sformatf("f%0d_cnt1", e.id), longint'(cnt1), longint'(e.c1));
          chk($sformatf("f%0d_cnt2", e.id), longint'(cnt2), longint'(e.c2));
          chk($sformatf("f%0d_seq", e.id), longint'(seq_err), longint'(e.seq));
          chk($sformatf("f%0d_sat", e.id), longint'(sat_err), longint'(e.sat));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    cds_clk1 = 1'b0; cds_clk2 = 1'b0; cds_done = 1'b0; adc_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    idle(2);

    // Nominal frame, done in the cycle cds_clk2 falls
    win(1'b1, 1'b0, 12'd1000, 2); idle(88); win(1'b0, 1'b1, 12'd400, 2);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(1, 1200, 2000, 800, 2, 2, 0, 0);
    idle(3);

    // Negative difference
    win(1'b1, 1'b0, 12'd100, 3); idle(5); win(1'b0, 1'b1, 12'd4095, 3);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(2, -11985, 300, 12285, 3, 3, 0, 0);
    idle(3);

    // Done while cds_clk2 still high: that last sample is included
    win(1'b1, 1'b0, 12'd50, 2); idle(3); win(1'b0, 1'b1, 12'd10, 2);
    step(1'b0, 1'b1, 1'b1, 12'd10); push_exp(3, 70, 100, 30, 2, 3, 0, 0);
    idle(3);

    // Back-to-back frames about 100 us apart, no residue between them
    win(1'b1, 1'b0, 12'd7, 1); idle(1); win(1'b0, 1'b1, 12'd3, 1);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(4, 4, 7, 3, 1, 1, 0, 0);
    idle(1995);
    win(1'b1, 1'b0, 12'd20, 4); idle(2); win(1'b0, 1'b1, 12'd5, 2);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(5, 70, 80, 10, 4, 2, 0, 0);
    idle(3);

    // Done during GAP
    win(1'b1, 1'b0, 12'd200, 2); idle(2);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(6, 400, 400, 0, 2, 0, 1, 0);
    idle(3);

    // cds_clk2 alone in IDLE: no result, error carried into the next frame
    win(1'b0, 1'b1, 12'd77, 2); idle(3);
    win(1'b1, 1'b0, 12'd5, 1); idle(1); win(1'b0, 1'b1, 12'd2, 1);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(7, 3, 5, 2, 1, 1, 1, 0);
    idle(3);
    win(1'b1, 1'b0, 12'd5, 1); idle(1); win(1'b0, 1'b1, 12'd2, 1);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(8, 3, 5, 2, 1, 1, 0, 0);
    idle(3);

    // Window-1 count saturation
    win(1'b1, 1'b0, 12'd1, 300); idle(1); win(1'b0, 1'b1, 12'd1, 1);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(9, 254, 255, 1, 255, 1, 0, 1);
    idle(3);

    // Async reset mid-WIN2 clears outputs without a clock edge
    win(1'b1, 1'b0, 12'd9, 2); idle(1); win(1'b0, 1'b1, 12'd9, 2);
    @(posedge clk);
    #10 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    cds_clk1 = 1'b0; cds_clk2 = 1'b0; cds_done = 1'b0; adc_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(10);

    // Full frame after reset
    win(1'b1, 1'b0, 12'd1000, 2); idle(4); win(1'b0, 1'b1, 12'd1, 2);
    step(1'b0, 1'b0, 1'b1, '0); push_exp(10, 1998, 2000, 2, 2, 2, 0, 0);
    idle(20);

    chk("pending_results", longint'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
